fir_sequencer: RTL and testbench

- Control FSM that sequences the 4-tap FIR datapath: register-file ALU, sample counter and coefficient store.
- Each accepted sample triggers a fixed micro-op sequence: history shift, sample load, alternating-sign multiply-accumulate.
- Also runs coefficient loading and error reporting.
- Sits between the input synchronizer/edge-detect logic and the datapath; drives cnt_up/clear of the 1000-sample counter.

---
 rtl/fir_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_fir_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
//
// Control FSM for the 4-tap FIR datapath. Each accepted sample runs a fixed
// eleven-cycle micro-op program on the register-file ALU:
//   shift history (R4<-R3, R3<-R2, R2<-R1), load the new sample into R1, then
//   R0 = R1*F0 - R2*F1 + R3*F2 - R4*F3 using R9 as product scratch.
// It also sequences coefficient loads (F0..F3 into R5..R8) and reports
// aborted sequences (ALU overflow, or the sample vanishing before it is
// stored).
//
// Register map: R0 result, R1..R4 sample history (R1 newest),
//               R5..R8 coefficients F0..F3, R9 product scratch.
//
// Ports:
//   clk       system clock
//   n_rst     asynchronous active-low reset
//   dr        data ready; must still be high when the sample is stored
//   lc        load-coefficient request, held until modwait is seen high
//   overflow  combinational ALU overflow for the op currently issued
//   cnt_up    sample-counter increment, one cycle per stored sample
//   clear     sample-counter clear, issued with the F0 load
//   modwait   sequencer busy
//   op        datapath opcode (NOP/COPY/LOAD1/LOAD2/ADD/SUB/MUL)
//   src1/src2 ALU operand register selects (0 when unused)
//   dest      write-back register select (0 for NOP)
//   err       sequence aborted
//
// Build option:
//   FIR_SEQ_STICKY_ERR_EN  when defined, err stays set across later sample
//                          sequences and clears only when an F0 coefficient
//                          load starts (or on reset). Otherwise err is high
//                          only while parked in the error-idle state.
// -----------------------------------------------------------------------------
module fir_sequencer #(
    parameter int REG_SEL_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    dr,
    input  logic                    lc,
    input  logic                    overflow,
    output logic                    cnt_up,
    output logic                    clear,
    output logic                    modwait,
    output logic [2:0]              op,
    output logic [REG_SEL_BITS-1:0] src1,
    output logic [REG_SEL_BITS-1:0] src2,
    output logic [REG_SEL_BITS-1:0] dest,
    output logic                    err
);

    // State encoding
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SHIFT3 = 4'd1;
    localparam logic [3:0] S_SHIFT2 = 4'd2;
    localparam logic [3:0] S_SHIFT1 = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_MUL1   = 4'd5;
    localparam logic [3:0] S_MUL2   = 4'd6;
    localparam logic [3:0] S_SUB1   = 4'd7;
    localparam logic [3:0] S_MUL3   = 4'd8;
    localparam logic [3:0] S_ADD1   = 4'd9;
    localparam logic [3:0] S_MUL4   = 4'd10;
    localparam logic [3:0] S_SUB2   = 4'd11;
    localparam logic [3:0] S_EIDLE  = 4'd12;
    localparam logic [3:0] S_LOADC  = 4'd13;
    localparam logic [3:0] S_WAITC  = 4'd14;

    // Datapath opcodes
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_COPY  = 3'd1;
    localparam logic [2:0] OP_LOAD1 = 3'd2;
    localparam logic [2:0] OP_LOAD2 = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    // Register selects
    localparam logic [REG_SEL_BITS-1:0] R0 = REG_SEL_BITS'(0);
    localparam logic [REG_SEL_BITS-1:0] R1 = REG_SEL_BITS'(1);
    localparam logic [REG_SEL_BITS-1:0] R2 = REG_SEL_BITS'(2);
    localparam logic [REG_SEL_BITS-1:0] R3 = REG_SEL_BITS'(3);
    localparam logic [REG_SEL_BITS-1:0] R4 = REG_SEL_BITS'(4);
    localparam logic [REG_SEL_BITS-1:0] R5 = REG_SEL_BITS'(5);
    localparam logic [REG_SEL_BITS-1:0] R6 = REG_SEL_BITS'(6);
    localparam logic [REG_SEL_BITS-1:0] R7 = REG_SEL_BITS'(7);
    localparam logic [REG_SEL_BITS-1:0] R8 = REG_SEL_BITS'(8);
    localparam logic [REG_SEL_BITS-1:0] R9 = REG_SEL_BITS'(9);

    logic [3:0] state_q, state_d;
    logic [1:0] k_q, k_d;          // next coefficient slot to load
    logic       alu_state;

    // States whose op can raise the ALU overflow flag
    assign alu_state = (state_q >= S_MUL1) && (state_q <= S_SUB2);

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE, S_EIDLE: begin
                // A new sample wins over a coefficient request.
                if (dr)      state_d = S_SHIFT3;
                else if (lc) state_d = S_LOADC;
            end
            S_SHIFT3: state_d = S_SHIFT2;
            S_SHIFT2: state_d = S_SHIFT1;
            // The sample is latched on the edge that enters STORE; if dr has
            // already gone away there is nothing to load, so the sequence is
            // abandoned before STORE ever issues LOAD1/cnt_up.
            S_SHIFT1: state_d = dr ? S_STORE : S_EIDLE;
            S_STORE:  state_d = S_MUL1;
            S_MUL1:   state_d = S_MUL2;
            S_MUL2:   state_d = S_SUB1;
            S_SUB1:   state_d = S_MUL3;
            S_MUL3:   state_d = S_ADD1;
            S_ADD1:   state_d = S_MUL4;
            S_MUL4:   state_d = S_SUB2;
            S_SUB2:   state_d = S_IDLE;
            S_LOADC:  state_d = S_WAITC;
            S_WAITC: begin
                if (!lc) begin
                    state_d = S_IDLE;
                    k_d     = k_q + 2'd1;   // wraps F3 -> F0
                end
            end
            default:  state_d = S_IDLE;
        endcase
        // The faulting op still issues this cycle; only the successor changes.
        if (alu_state && overflow) state_d = S_EIDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        op      = OP_NOP;
        src1    = R0;
        src2    = R0;
        dest    = R0;
        cnt_up  = 1'b0;
        clear   = 1'b0;
        modwait = 1'b1;
        case (state_q)
            S_IDLE, S_EIDLE: modwait = 1'b0;
            S_SHIFT3: begin op = OP_COPY;  src1 = R3; dest = R4; end
            S_SHIFT2: begin op = OP_COPY;  src1 = R2; dest = R3; end
            S_SHIFT1: begin op = OP_COPY;  src1 = R1; dest = R2; end
            S_STORE:  begin op = OP_LOAD1; dest = R1; cnt_up = 1'b1; end
            S_MUL1:   begin op = OP_MUL;   src1 = R1; src2 = R5; dest = R0; end
            S_MUL2:   begin op = OP_MUL;   src1 = R2; src2 = R6; dest = R9; end
            S_SUB1:   begin op = OP_SUB;   src1 = R0; src2 = R9; dest = R0; end
            S_MUL3:   begin op = OP_MUL;   src1 = R3; src2 = R7; dest = R9; end
            S_ADD1:   begin op = OP_ADD;   src1 = R0; src2 = R9; dest = R0; end
            S_MUL4:   begin op = OP_MUL;   src1 = R4; src2 = R8; dest = R9; end
            S_SUB2:   begin op = OP_SUB;   src1 = R0; src2 = R9; dest = R0; end
            S_LOADC: begin
                op    = OP_LOAD2;
                dest  = R5 + REG_SEL_BITS'(k_q);
                // Starting a fresh coefficient set restarts the sample count.
                clear = (k_q == 2'd0);
            end
            S_WAITC:  op = OP_NOP;
            default:  modwait = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Error flag
    // -------------------------------------------------------------------------
`ifdef FIR_SEQ_STICKY_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_d == S_EIDLE)
            err_d = 1'b1;
        else if (state_d == S_LOADC && k_q == 2'd0)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = (state_q == S_EIDLE);
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
//
// Drives fir_sequencer with directed scenarios followed by random dr/lc/
// overflow traffic. A table-driven reference model predicts every output
// each cycle; a small behavioural register file executes the issued ops so
// the FIR result in R0 can be compared against the arithmetic definition
// h0*F0 - h1*F1 + h2*F2 - h3*F3 after every completed sequence.
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

    localparam int RSB = 4;

    logic           clk = 1'b0;
    logic           n_rst, dr, lc, overflow;
    logic           cnt_up, clear, modwait, err;
    logic [2:0]     op;
    logic [RSB-1:0] src1, src2, dest;

    always #5 clk = ~clk;

    fir_sequencer #(.REG_SEL_BITS(RSB)) dut (
        .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
        .cnt_up(cnt_up), .clear(clear), .modwait(modwait),
        .op(op), .src1(src1), .src2(src2), .dest(dest), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SEQ = 1, M_EIDLE = 2, M_LOADC = 3, M_WAITC = 4;

    // micro-op program of one sample sequence, one entry per cycle
    int t_op[11] = '{1, 1, 1, 2, 6, 6, 5, 6, 4, 6, 5};
    int t_s1[11] = '{3, 2, 1, 0, 1, 2, 0, 3, 0, 4, 0};
    int t_s2[11] = '{0, 0, 0, 0, 5, 6, 9, 7, 9, 8, 9};
    int t_d [11] = '{4, 3, 2, 1, 0, 9, 0, 9, 0, 9, 0};

    int  m_mode, m_step, m_k;
    bit  m_err, r0_due;
    int  h[4];          // sample history, h[0] newest
    int  c[4];          // coefficients F0..F3
    int  rf[16];        // behavioural register file
    int  sample_v, coeff_v;
    int  n_cu, n_clr, n_mw;
    logic first_err;

    function automatic logic [31:0] pack(int o, int s1, int s2, int d,
                                         int cu, int clr, int mw, int er);
        return (o << 16) | (s1 << 12) | (s2 << 8) | (d << 4) |
               (cu << 3) | (clr << 2) | (mw << 1) | er;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {13'd0, op, src1, src2, dest, cnt_up, clear, modwait, err};
    endfunction

    function automatic logic [31:0] model_out();
        int o = 0, s1 = 0, s2 = 0, d = 0, cu = 0, clr = 0, mw = 0, er = 0;
        case (m_mode)
            M_SEQ: begin
                o = t_op[m_step]; s1 = t_s1[m_step]; s2 = t_s2[m_step];
                d = t_d[m_step];  cu = (m_step == 3) ? 1 : 0; mw = 1;
            end
            M_EIDLE: er = 1;
            M_LOADC: begin o = 3; d = 5 + m_k; mw = 1; clr = (m_k == 0) ? 1 : 0; end
            M_WAITC: mw = 1;
            default: ;
        endcase
`ifdef FIR_SEQ_STICKY_ERR_EN
        er = m_err ? 1 : 0;
`endif
        return pack(o, s1, s2, d, cu, clr, mw, er);
    endfunction

    task automatic model_step(input bit d, input bit l, input bit o, input int smp, input int cf);
        r0_due = 0;
        case (m_mode)
            M_IDLE, M_EIDLE: begin
                if (d) begin
                    m_mode = M_SEQ; m_step = 0;
                end else if (l) begin
                    m_mode = M_LOADC;
                    if (m_k == 0) m_err = 0;
                end
            end
            M_SEQ: begin
                case (m_step)
                    0: h[3] = h[2];
                    1: h[2] = h[1];
                    2: h[1] = h[0];
                    3: h[0] = smp;
                    default: ;
                endcase
                if (m_step == 2 && !d) begin
                    m_mode = M_EIDLE; m_err = 1;
                end else if (m_step >= 4 && o) begin
                    m_mode = M_EIDLE; m_err = 1;
                end else if (m_step == 10) begin
                    m_mode = M_IDLE; r0_due = 1;
                end else begin
                    m_step++;
                end
            end
            M_LOADC: begin c[m_k] = cf; m_mode = M_WAITC; end
            M_WAITC: if (!l) begin m_mode = M_IDLE; m_k = (m_k + 1) % 4; end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic exec(input int o, input int s1, input int s2, input int d,
                        input int smp, input int cf);
        case (o)
            1: rf[d] = rf[s1];
            2: rf[d] = smp;
            3: rf[d] = cf;
            4: rf[d] = rf[s1] + rf[s2];
            5: rf[d] = rf[s1] - rf[s2];
            6: rf[d] = rf[s1] * rf[s2];
            default: ;
        endcase
    endtask

    // one clock: drive, clock, advance model and register file, check outputs
    task automatic cycle(input bit d, input bit l, input bit o);
        int cop, cs1, cs2, cd, smp, cf;
        dr = d; lc = l; overflow = o;
        cop = int'(op); cs1 = int'(src1); cs2 = int'(src2); cd = int'(dest);
        smp = sample_v; cf = coeff_v;
        @(posedge clk);
        model_step(d, l, o, smp, cf);
        exec(cop, cs1, cs2, cd, smp, cf);
        if (r0_due)
            chk("r0", rf[0], h[0]*c[0] - h[1]*c[1] + h[2]*c[2] - h[3]*c[3]);
        #1;
        chk("outs", dut_vec(), model_out());
        if (cnt_up === 1'b1)  n_cu++;
        if (clear === 1'b1)   n_clr++;
        if (modwait === 1'b1) n_mw++;
    endtask

    task automatic do_reset();
        dr = 0; lc = 0; overflow = 0;
        n_rst = 0;
        #1;
        m_mode = M_IDLE; m_step = 0; m_k = 0; m_err = 0;
        chk("rst_async", dut_vec(), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold", dut_vec(), model_out());
        n_rst = 1;
    endtask

    task automatic run_sample(input int s, input int ov_step, input int dr_len,
                              output int cu, output int mw);
        int cu0 = n_cu;
        int mw0 = n_mw;
        sample_v = s;
        for (int i = 0; i < 20; i++) begin
            cycle(i < dr_len, 1'b0, (m_mode == M_SEQ && m_step == ov_step));
            if (i == 0) first_err = err;
            if (m_mode != M_SEQ) break;
        end
        cu = n_cu - cu0;
        mw = n_mw - mw0;
    endtask

    task automatic load_coef(input int cv, input int idx, input int clr_e);
        coeff_v = cv;
        cycle(1'b0, 1'b1, 1'b0);
        chk("ld_op", op, 3);
        chk("ld_dest", dest, 5 + idx);
        chk("ld_clr", clear, clr_e);
        chk("ld_mw", modwait, 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("wt_op", op, 0);
        chk("wt_mw", modwait, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("ld_idle", modwait, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cu, mw, mw0, clr0;
        n_rst = 1; dr = 0; lc = 0; overflow = 0;
        sample_v = 0; coeff_v = 0;
        m_mode = M_IDLE; m_step = 0; m_k = 0; m_err = 0; r0_due = 0;
        n_cu = 0; n_clr = 0; n_mw = 0;
        for (int i = 0; i < 4; i++) begin h[i] = 0; c[i] = 0; end
        for (int i = 0; i < 16; i++) rf[i] = 0;
        #1;
        do_reset();

        // coefficient loads 1..4, then a wrapped set of 1s
        clr0 = n_clr;
        for (int i = 0; i < 4; i++) load_coef(i + 1, i, (i == 0) ? 1 : 0);
        chk("clr_cnt", n_clr - clr0, 1);
        chk("coef_r8", rf[8], 4);
        for (int i = 0; i < 4; i++) load_coef(1, i, (i == 0) ? 1 : 0);

        // clean samples
        for (int i = 0; i < 4; i++) begin
            run_sample(10 * (i + 1), -1, 4, cu, mw);
            chk("smp_cu", cu, 1);
            chk("smp_lat", mw, 11);
        end
        chk("fir_r0", rf[0], 20);

        // overflow during ADD1
        run_sample(50, 8, 4, cu, mw);
        chk("ov_err", err, 1);
        chk("ov_mw", modwait, 0);
        chk("ov_mw_n", mw, 9);
        chk("ov_cu", cu, 1);

        // next sample clears err and restarts at SHIFT3
        run_sample(60, -1, 4, cu, mw);
`ifndef FIR_SEQ_STICKY_ERR_EN
        chk("err_clr", first_err, 0);
`endif
        chk("re_lat", mw, 11);

        // dr dropped before STORE
        run_sample(70, -1, 1, cu, mw);
        chk("lost_cu", cu, 0);
        chk("lost_err", err, 1);
        chk("lost_mw_n", mw, 3);

        // back to IDLE, then dr and lc together
        run_sample(80, -1, 4, cu, mw);
        mw0 = n_mw;
        cycle(1'b1, 1'b1, 1'b0);
        chk("both_op", op, 1);
        chk("both_src", src1, 3);
        for (int i = 0; i < 20; i++) begin
            cycle(i < 3, 1'b1, 1'b0);
            if (m_mode == M_LOADC) break;
        end
        chk("both_ld", op, 3);
        chk("both_mw_n", n_mw - mw0, 12);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // reset in the middle of MUL2
        sample_v = 85;
        for (int i = 0; i < 20; i++) begin
            cycle(i < 4, 1'b0, 1'b0);
            if (m_mode == M_SEQ && m_step == 5) break;
        end
        chk("pre_rst_op", op, 6);
        do_reset();
        run_sample(90, -1, 4, cu, mw);
        chk("post_rst_cu", cu, 1);
        chk("post_rst_lat", mw, 11);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            sample_v = $urandom_range(0, 255);
            coeff_v  = $urandom_range(0, 15);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
